// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2
  } scan_state_e;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;
  localparam int KEY_W    = $clog2(ROWS_DEF * COLS_DEF);

  function automatic int key_pack(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_debounce_cell.sv
// Per-key debouncer: a key's stable state flips only after DEBOUNCE_SCANS
// consecutive scan samples disagree with it; rise/fall pulse on the flip.
module keypad_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic sample_bit,
  input  logic sample_stb,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic [3:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sample_stb) begin
      if (sample_bit == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == 4'(DEBOUNCE_SCANS - 1)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        rise_d   = ~stable_q;
        fall_d   = stable_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/keypad_row_scanner.sv
// Keypad matrix scanner: one-hot row drive, per-key debounce, key-code events
// over valid/ready. Define KEYPAD_RELEASE_EVENT_EN to also report releases.
//
// state    | meaning
// S_IDLE   | single cycle after reset before the first row is driven
// S_DRIVE  | row r driven, settle timer counting down
// S_SAMPLE | synchronised columns handed to row r's debounce cells
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = ROWS_DEF,
  parameter int COLS           = COLS_DEF,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [COLS-1:0]               col_in,
  output logic [ROWS-1:0]               row_out,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_release,
  input  logic                          key_ready,
  output logic                          key_down,
  output logic                          scan_wrap
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = (ROWS == ROWS_DEF && COLS == COLS_DEF) ? KEY_W : $clog2(NKEYS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [COLS-1:0] col_meta_q, col_sync_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      col_meta_q <= '0;
      col_sync_q <= '0;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  scan_state_e     state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic            scan_wrap_q, scan_wrap_d;
  logic [ROWS-1:0] row_stb;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    settle_d    = settle_q;
    row_out_d   = '0;
    scan_wrap_d = 1'b0;
    row_stb     = '0;
    case (state_q)
      S_IDLE: begin
        state_d  = S_DRIVE;
        row_d    = '0;
        settle_d = CW'(SETTLE_CYCLES - 1);
      end
      S_DRIVE: begin
        row_out_d = ROWS'(1) << row_q;
        if (settle_q == '0) state_d = S_SAMPLE;
        else                settle_d = settle_q - CW'(1);
      end
      S_SAMPLE: begin
        row_out_d = ROWS'(1) << row_q;
        row_stb   = ROWS'(1) << row_q;
        state_d   = S_DRIVE;
        settle_d  = CW'(SETTLE_CYCLES - 1);
        if (row_q == RW'(ROWS - 1)) begin
          row_d       = '0;
          scan_wrap_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      settle_q    <= '0;
      row_out_q   <= '0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      settle_q    <= settle_d;
      row_out_q   <= row_out_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  logic [NKEYS-1:0] stable, rise, fall;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = key_pack(r, c, COLS);
      keypad_debounce_cell #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_cell (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .sample_bit(col_sync_q[c]),
        .sample_stb(row_stb[r]),
        .stable    (stable[K]),
        .rise      (rise[K]),
        .fall      (fall[K])
      );
    end
  end

  logic [NKEYS-1:0] pend_press_q, pend_press_d;
  logic             key_valid_q, key_valid_d;
  logic [KW-1:0]    key_code_q, key_code_d;
  logic             key_down_q;
  logic             pick_found;
  logic [KW-1:0]    pick_idx;
  logic             load;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [NKEYS-1:0] pend_rel_q, pend_rel_d;
  logic             key_release_q, key_release_d;
  logic             pick_rel;
`endif

  // Descending walk so the lowest key wins; a key's press outranks its release.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    pick_rel   = 1'b0;
`endif
    for (int k = NKEYS - 1; k >= 0; k--) begin
`ifdef KEYPAD_RELEASE_EVENT_EN
      if (pend_rel_q[k]) begin
        pick_found = 1'b1;
        pick_idx   = KW'(k);
        pick_rel   = 1'b1;
      end
`endif
      if (pend_press_q[k]) begin
        pick_found = 1'b1;
        pick_idx   = KW'(k);
`ifdef KEYPAD_RELEASE_EVENT_EN
        pick_rel   = 1'b0;
`endif
      end
    end
  end

  assign load = !key_valid_q || key_ready;

  // New pending bits are merged after the emitter clear, so a set wins.
  always_comb begin
    pend_press_d = pend_press_q;
    key_valid_d  = key_valid_q;
    key_code_d   = key_code_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
    pend_rel_d    = pend_rel_q;
    key_release_d = key_release_q;
`endif
    if (load) begin
      key_valid_d = pick_found;
      if (pick_found) begin
        key_code_d = pick_idx;
`ifdef KEYPAD_RELEASE_EVENT_EN
        key_release_d = pick_rel;
        if (pick_rel) pend_rel_d[pick_idx] = 1'b0;
        else          pend_press_d[pick_idx] = 1'b0;
`else
        pend_press_d[pick_idx] = 1'b0;
`endif
      end
    end
    pend_press_d = (pend_press_d & ~fall) | rise;
`ifdef KEYPAD_RELEASE_EVENT_EN
    pend_rel_d = pend_rel_d | fall;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_press_q <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_down_q   <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      pend_rel_q    <= '0;
      key_release_q <= 1'b0;
`endif
    end else begin
      pend_press_q <= pend_press_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_down_q   <= |stable;
`ifdef KEYPAD_RELEASE_EVENT_EN
      pend_rel_q    <= pend_rel_d;
      key_release_q <= key_release_d;
`endif
    end
  end

  assign row_out   = row_out_q;
  assign scan_wrap = scan_wrap_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign key_release = key_release_q;
`else
  assign key_release = 1'b0;
`endif

endmodule

// File: doc/keypad_row_scanner.md
Name: keypad_row_scanner

Overview:
Active scanner for the 4x4 push-button matrix.
- Drives one row at a time.
- Samples the column lines and debounces each of the 16 keys independently.
- Delivers press events as key codes through a valid/ready handshake to the AHB key peripheral/CPU side.
- This is the drive side of the matrix; col inputs are high when a key on the driven row is pressed.

Parameters:
ROWS, 4, number of matrix rows driven (one-hot)
COLS, 4, number of column inputs sampled
SETTLE_CYCLES, 16, HCLK cycles each row is driven before sampling (≥2)
DEBOUNCE_SCANS, 4, consecutive identical full-scan samples required to change a key's stable state (1..15)

Ports:
HCLK  input  1  system clock, all logic on posedge
HRESETn  input  1  reset, synchronous, active-low
col_in  input  COLS  column sense lines, 1 = pressed on driven row; synchronised internally by 2 flops
row_out  output  ROWS  one-hot row drive, 1 = driven
key_valid  output  1  event holding register full
key_code  output  $clog2(ROWS*COLS)  key index = row*COLS + col
key_release  output  1  1 = release event (only with optional feature, else constant 0)
key_ready  input  1  consumer accepts event when key_valid & key_ready
key_down  output  1  OR of all debounced stable states
scan_wrap  output  1  one-cycle pulse when the last row's sample completes

Behaviour:
- Reset (HRESETn low at posedge): row_out=0, key_valid=0, key_code=0, key_release=0, key_down=0, scan_wrap=0. FSM=S_IDLE. All debounce counters, stable states and pending bits cleared.
- FSM states:
  - S_IDLE: one cycle after reset → S_DRIVE with row index r=0.
  - S_DRIVE: row_out = 1<<r; settle counter counts 0..SETTLE_CYCLES-1. At terminal count → S_SAMPLE.
  - S_SAMPLE: row_out still 1<<r; synchronised col_in latched into sample[r]. If r==ROWS-1 → r=0, scan_wrap=1; else r+1. → S_DRIVE.
- Scan period: ROWS*(SETTLE_CYCLES+1) cycles = 68 at defaults; r wraps to 0 with no idle gap.
- Debounce per key, updated in that key's row S_SAMPLE cycle:
  - If sample == stable: counter := 0.
  - Else counter +1. When counter reaches DEBOUNCE_SCANS-1 on a mismatch: stable toggles, counter := 0, pending bit set.
- Pending bits:
  - Press pending is cleared if the key's stable state returns to 0 before being emitted; no stale press is reported.
  - Without the optional feature, only 0→1 transitions set pending.
- Emitter:
  - When key_valid==0 or key_valid&key_ready, load the lowest-index pending key into key_code/key_release next cycle and clear its bit.
  - Back-to-back events are allowed (accept and reload in the same cycle).
- key_valid stays high with key_code stable until accepted; no events are dropped (pending bits buffer them).
- Simultaneous pending bit set and emitter clear on the same key: set wins.
- key_down registered, updated the cycle after stable changes.
- Ghosting (3+ keys on a rectangle) is not resolved; it is reported as sampled.

Optional Feature:
Macro KEYPAD_RELEASE_EVENT_EN.
- Defined: 1→0 stable transitions also set pending, emitted with key_release=1. A press and a release of the same key are tracked by separate pending vectors; the press is emitted first.
- Undefined: release logic is absent, key_release tied 0, and only presses are reported.

Decomposition:
- Package keypad_pkg: FSM state typedef (S_IDLE, S_DRIVE, S_SAMPLE), default ROWS/COLS, KEY_W = $clog2(ROWS*COLS), key-code pack function (row*COLS+col).
- Sub-module keypad_debounce_cell, instanced ROWS*COLS times:
  - Inputs: sample bit and sample strobe.
  - Holds counter and stable state.
  - Outputs: stable, rise pulse, fall pulse.
- Top holds the FSM, synchroniser, pending vectors, priority picker and output register.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles with col_in=4'hF → all outputs 0. First posedge after release: row_out=0. Next 17 cycles: row_out=4'b0001. scan_wrap pulses every 68 cycles.
- Single press: col_in[1]=1 whenever row_out[2]=1, held → within 4 scans (≤272+4 cycles) key_valid=1, key_code=9. Hold key_ready=0 for 500 cycles → key_valid and code stable, no second event; key_down=1.
- Bounce: toggle key 5 each scan for 10 scans → no event. Then hold steady 4 scans → exactly one event, code 5.
- Simultaneous: keys 3 and 12 pressed in the same scan, key_ready=1 → events 3 then 12 on consecutive valid cycles.
- Short glitch: press key 0 for 2 scans only (DEBOUNCE_SCANS=4) → no event, key_down stays 0.
- Release (KEYPAD_RELEASE_EVENT_EN): press and release key 15 → event code 15, release=0, then code 15, release=1. Without the macro → only the first event.
